// File: rtl/sdram_cpu_bridge_if.sv
// rtl/sdram_cpu_bridge_if.sv - CPU strobe bus and SDRAM controller port bundle for sdram_cpu_bridge
interface sdram_cpu_bridge_if;
    // CPU side
    logic [23:0] cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_rdy;
    logic        cpu_busy;
    // SDRAM controller side
    logic        sd_req;
    logic        sd_ack;
    logic [22:0] sd_addr;
    logic [1:0]  sd_ds;
    logic        sd_we;
    logic [15:0] sd_din;
    logic [15:0] sd_dout;
    logic        sd_port;

    // Bridge view: consumes CPU strobes and controller acks, drives everything else
    modport slave (
        input  cpu_addr, cpu_rd, cpu_wr, cpu_dout, sd_ack, sd_dout,
        output cpu_din, cpu_rdy, cpu_busy, sd_req, sd_addr, sd_ds, sd_we, sd_din, sd_port
    );

    // Environment view: the CPU and the SDRAM controller together
    modport master (
        output cpu_addr, cpu_rd, cpu_wr, cpu_dout, sd_ack, sd_dout,
        input  cpu_din, cpu_rdy, cpu_busy, sd_req, sd_addr, sd_ds, sd_we, sd_din, sd_port
    );
endinterface

// File: rtl/sdram_cpu_bridge.sv
// rtl/sdram_cpu_bridge.sv - 8-bit CPU strobes to 16-bit toggle req/ack SDRAM port; optional one-word read buffer via SDRAM_BRIDGE_WBUF_EN
module sdram_cpu_bridge #(
    parameter int RD_DLY   = 5,
    parameter int PORT_SEL = 0
) (
    input  logic               clk,
    input  logic               init_n,
    sdram_cpu_bridge_if.slave  bus
);

    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_REQ   = 2'd2;
    localparam logic [1:0] ST_WAITD = 2'd3;

    localparam int CW = (RD_DLY < 2) ? 1 : $clog2(RD_DLY + 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          lane;       // byte address bit 0 of the access in flight
    logic          sd_req_r;
    logic [22:0]   sd_addr_r;
    logic [1:0]    sd_ds_r;
    logic          sd_we_r;
    logic [15:0]   sd_din_r;
    logic [7:0]    cpu_din_r;
    logic          cpu_rdy_r;
    logic          cpu_busy_r;

`ifdef SDRAM_BRIDGE_WBUF_EN
    logic          buf_valid;
    logic [22:0]   buf_tag;
    logic [15:0]   buf_word;
    logic          buf_hit;

    // The strobe's word address matches the buffered word
    always_comb begin
        buf_hit = buf_valid && (buf_tag == bus.cpu_addr[23:1]);
    end
`endif

    assign bus.sd_req   = sd_req_r;
    assign bus.sd_addr  = sd_addr_r;
    assign bus.sd_ds    = sd_ds_r;
    assign bus.sd_we    = sd_we_r;
    assign bus.sd_din   = sd_din_r;
    assign bus.sd_port  = 1'(PORT_SEL);
    assign bus.cpu_din  = cpu_din_r;
    assign bus.cpu_rdy  = cpu_rdy_r;
    assign bus.cpu_busy = cpu_busy_r;

    // Access sequencer: accept a strobe, toggle the request, wait for ack and data, pulse completion
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state      <= ST_SYNC;
            cnt        <= '0;
            lane       <= 1'b0;
            sd_req_r   <= 1'b0;
            sd_addr_r  <= '0;
            sd_ds_r    <= '0;
            sd_we_r    <= 1'b0;
            sd_din_r   <= '0;
            cpu_din_r  <= '0;
            cpu_rdy_r  <= 1'b0;
            cpu_busy_r <= 1'b1;
`ifdef SDRAM_BRIDGE_WBUF_EN
            buf_valid  <= 1'b0;
            buf_tag    <= '0;
            buf_word   <= '0;
`endif
        end else begin
            cpu_rdy_r <= 1'b0;
            case (state)
                ST_SYNC: begin
                    // The controller's ack survives our reset; align to it so no toggle is pending
                    sd_req_r   <= bus.sd_ack;
                    cpu_busy_r <= 1'b0;
                    state      <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (bus.cpu_wr) begin
                        lane       <= bus.cpu_addr[0];
                        sd_addr_r  <= bus.cpu_addr[23:1];
                        sd_we_r    <= 1'b1;
                        sd_din_r   <= {bus.cpu_dout, bus.cpu_dout};
                        sd_ds_r    <= {bus.cpu_addr[0], ~bus.cpu_addr[0]};
                        sd_req_r   <= ~sd_req_r;
                        cpu_busy_r <= 1'b1;
                        state      <= ST_REQ;
`ifdef SDRAM_BRIDGE_WBUF_EN
                        if (buf_hit) begin
                            if (bus.cpu_addr[0])
                                buf_word[15:8] <= bus.cpu_dout;
                            else
                                buf_word[7:0]  <= bus.cpu_dout;
                        end
`endif
                    end else if (bus.cpu_rd) begin
`ifdef SDRAM_BRIDGE_WBUF_EN
                        if (buf_hit) begin
                            cpu_din_r <= bus.cpu_addr[0] ? buf_word[15:8] : buf_word[7:0];
                            cpu_rdy_r <= 1'b1;
                        end else
`endif
                        begin
                            lane       <= bus.cpu_addr[0];
                            sd_addr_r  <= bus.cpu_addr[23:1];
                            sd_we_r    <= 1'b0;
                            sd_ds_r    <= 2'b11;
                            sd_req_r   <= ~sd_req_r;
                            cpu_busy_r <= 1'b1;
                            state      <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.sd_ack == sd_req_r) begin
                        if (sd_we_r) begin
                            cpu_rdy_r  <= 1'b1;
                            cpu_busy_r <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            cnt   <= CW'(RD_DLY);
                            state <= ST_WAITD;
                        end
                    end
                end
                ST_WAITD: begin
                    // Read data lands in the controller's port register some cycles after the ack
                    if (cnt == '0) begin
                        cpu_din_r  <= lane ? bus.sd_dout[15:8] : bus.sd_dout[7:0];
                        cpu_rdy_r  <= 1'b1;
                        cpu_busy_r <= 1'b0;
                        state      <= ST_IDLE;
`ifdef SDRAM_BRIDGE_WBUF_EN
                        buf_valid  <= 1'b1;
                        buf_tag    <= sd_addr_r;
                        buf_word   <= bus.sd_dout;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_cpu_bridge.sv
// tb/tb_sdram_cpu_bridge.sv - directed self-checking bench for sdram_cpu_bridge
module tb_sdram_cpu_bridge;

`ifdef SDRAM_BRIDGE_WBUF_EN
    localparam bit WBUF = 1'b1;
`else
    localparam bit WBUF = 1'b0;
`endif

    logic clk = 1'b0;
    logic init_n = 1'b0;

    sdram_cpu_bridge_if bif();

    sdram_cpu_bridge #(.RD_DLY(5), .PORT_SEL(0)) dut (
        .clk    (clk),
        .init_n (init_n),
        .bus    (bif)
    );

    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_fail     = 0;
    int req_edges  = 0;
    int rdy_pulses = 0;
    int e0;
    int r0;

    always @(bif.sd_req) req_edges++;

    always @(posedge clk) if (bif.cpu_rdy === 1'b1) rdy_pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; holds the strobe for exactly one rising edge
    task automatic strobe(input logic rd, input logic wr, input logic [23:0] addr, input logic [7:0] data);
        bif.cpu_rd   = rd;
        bif.cpu_wr   = wr;
        bif.cpu_addr = addr;
        bif.cpu_dout = data;
        @(negedge clk);
        bif.cpu_rd   = 1'b0;
        bif.cpu_wr   = 1'b0;
    endtask

    task automatic ack_after(input int n);
        repeat (n) @(negedge clk);
        bif.sd_ack = bif.sd_req;
    endtask

    task automatic wait_rdy(input string tag, input int limit);
        int i;
        i = 0;
        while (bif.cpu_rdy !== 1'b1 && i < limit) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_rdy"}, 32'(bif.cpu_rdy), 32'd1);
    endtask

    // Read one byte; on a miss the controller model acks and presents dout
    task automatic do_read(input string tag, input logic [23:0] addr, input logic [15:0] dout,
                           input logic [7:0] exp_byte, input bit hit);
        int ed;
        ed = req_edges;
        strobe(1'b1, 1'b0, addr, 8'h00);
        if (hit) begin
            check({tag, "_hit_rdy"}, 32'(bif.cpu_rdy), 32'd1);
        end else begin
            check({tag, "_sd_we"}, 32'(bif.sd_we), 32'd0);
            check({tag, "_sd_ds"}, 32'(bif.sd_ds), 32'h3);
            check({tag, "_sd_addr"}, 32'(bif.sd_addr), 32'(addr[23:1]));
            bif.sd_dout = dout;
            ack_after(3);
            wait_rdy(tag, 40);
        end
        check({tag, "_din"}, 32'(bif.cpu_din), 32'(exp_byte));
        check({tag, "_busy"}, 32'(bif.cpu_busy), 32'd0);
        check({tag, "_toggles"}, 32'(req_edges - ed), hit ? 32'd0 : 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.cpu_addr = '0;
        bif.cpu_rd   = 1'b0;
        bif.cpu_wr   = 1'b0;
        bif.cpu_dout = '0;
        bif.sd_ack   = 1'b1;
        bif.sd_dout  = '0;
        init_n       = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_sd_req", 32'(bif.sd_req), 32'd0);
        check("rst_busy", 32'(bif.cpu_busy), 32'd1);
        check("rst_rdy", 32'(bif.cpu_rdy), 32'd0);
        check("rst_din", 32'(bif.cpu_din), 32'd0);
        check("rst_ds", 32'(bif.sd_ds), 32'd0);
        check("rst_we", 32'(bif.sd_we), 32'd0);
        check("sd_port", 32'(bif.sd_port), 32'd0);

        init_n = 1'b1;
        @(negedge clk);
        check("sync_req", 32'(bif.sd_req), 32'd1);
        check("sync_busy", 32'(bif.cpu_busy), 32'd0);
        e0 = req_edges;
        repeat (4) @(negedge clk);
        check("sync_no_txn", 32'(req_edges - e0), 32'd0);

        // Write to an odd byte: high lane
        e0 = req_edges;
        strobe(1'b0, 1'b1, 24'h012345, 8'hA5);
        check("wr_addr", 32'(bif.sd_addr), 32'h0091A2);
        check("wr_ds", 32'(bif.sd_ds), 32'h2);
        check("wr_din", 32'(bif.sd_din), 32'hA5A5);
        check("wr_we", 32'(bif.sd_we), 32'd1);
        check("wr_busy", 32'(bif.cpu_busy), 32'd1);
        check("wr_toggle", 32'(req_edges - e0), 32'd1);
        ack_after(2);
        check("wr_addr_stable", 32'(bif.sd_addr), 32'h0091A2);
        check("wr_no_early_rdy", 32'(bif.cpu_rdy), 32'd0);
        @(negedge clk);
        check("wr_rdy", 32'(bif.cpu_rdy), 32'd1);
        check("wr_busy_done", 32'(bif.cpu_busy), 32'd0);
        @(negedge clk);
        check("wr_rdy_pulse", 32'(bif.cpu_rdy), 32'd0);

        // Low lane miss, then high lane of the same word
        do_read("rd10", 24'h000010, 16'hBEEF, 8'hEF, 1'b0);
        do_read("rd11", 24'h000011, 16'hBEEF, 8'hBE, WBUF);

        // Write into the buffered word, then read it back
        strobe(1'b0, 1'b1, 24'h000011, 8'h5A);
        check("wr11_ds", 32'(bif.sd_ds), 32'h2);
        check("wr11_din", 32'(bif.sd_din), 32'h5A5A);
        ack_after(1);
        @(negedge clk);
        check("wr11_rdy", 32'(bif.cpu_rdy), 32'd1);
        @(negedge clk);
        do_read("rd11b", 24'h000011, 16'h5AEF, 8'h5A, WBUF);

        // Simultaneous strobes: the write wins; a strobe while busy is ignored
        e0 = req_edges;
        strobe(1'b1, 1'b1, 24'h000020, 8'h3C);
        check("both_we", 32'(bif.sd_we), 32'd1);
        check("both_ds", 32'(bif.sd_ds), 32'h1);
        check("both_din", 32'(bif.sd_din), 32'h3C3C);
        check("both_addr", 32'(bif.sd_addr), 32'h10);
        strobe(1'b1, 1'b0, 24'h000100, 8'h00);
        check("busy_strobe_addr", 32'(bif.sd_addr), 32'h10);
        check("busy_strobe_toggles", 32'(req_edges - e0), 32'd1);
        ack_after(1);
        @(negedge clk);
        check("both_rdy", 32'(bif.cpu_rdy), 32'd1);
        @(negedge clk);
        check("busy_strobe_dropped", 32'(req_edges - e0), 32'd1);

        // Top of the address space
        strobe(1'b0, 1'b1, 24'hFFFFFF, 8'h81);
        check("top_addr", 32'(bif.sd_addr), 32'h7FFFFF);
        check("top_ds", 32'(bif.sd_ds), 32'h2);
        ack_after(1);
        @(negedge clk);
        check("top_rdy", 32'(bif.cpu_rdy), 32'd1);
        @(negedge clk);

        // Reset while waiting for read data: no completion, request realigned to ack
        strobe(1'b1, 1'b0, 24'h000030, 8'h00);
        bif.sd_dout = 16'h1234;
        ack_after(1);
        repeat (2) @(negedge clk);
        r0 = rdy_pulses;
        init_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(bif.cpu_busy), 32'd1);
        init_n = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_rst_no_rdy", 32'(rdy_pulses - r0), 32'd0);
        check("mid_rst_req_eq_ack", 32'(bif.sd_req), 32'(bif.sd_ack));
        check("mid_rst_idle", 32'(bif.cpu_busy), 32'd0);

        // Buffer cleared by reset, so this misses; it then refills
        do_read("post_rst11", 24'h000011, 16'h6611, 8'h66, 1'b0);
        do_read("post_rst31", 24'h000031, 16'h1234, 8'h12, 1'b0);
        do_read("post_rst30", 24'h000030, 16'h1234, 8'h34, WBUF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
